// File: rtl/johnson_phase_monitor.sv
// Registers a Johnson count, classifies each step, decodes the phase and
// tracks lock, step errors and completed rotations.
module johnson_phase_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 2,
    parameter int CYC_W    = 8
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      en,
    input  logic [N-1:0]              q_in,
    output logic [2*N-1:0]            phase,
    output logic [$clog2(2*N)-1:0]    phase_idx,
    output logic                      locked,
    output logic                      err,
    output logic                      err_sticky,
    output logic [CYC_W-1:0]          cycle_cnt,
    output logic                      wrap
);

    localparam int P     = 2 * N;
    localparam int IDX_W = $clog2(P);
    localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_q;
    logic               r_q_valid;
    logic [IDX_W-1:0]   r_prev_idx;
    logic               r_prev_valid;
    logic [3:0]         r_match_cnt;

    logic               w_legal;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_adv;
    logic               w_hold;
    logic               w_bad;
    logic               w_rot;
    logic [3:0]         w_match_inc;
    logic [CYC_W-1:0]   w_cyc_inc;

    // Code k: low k bits set for k < N, else low k-N bits clear, rest set.
    function automatic logic [N-1:0] jcode(input int k);
        logic [N-1:0] c;
        for (int b = 0; b < N; b++)
            c[b] = (k < N) ? (b < k) : (b >= k - N);
        return c;
    endfunction

    always_comb begin
        w_legal = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < P; k++) begin
            if (r_q == jcode(k)) begin
                w_legal = 1'b1;
                w_idx   = IDX_W'(k);
            end
        end
    end

    assign w_next_idx  = (r_prev_idx == LAST_IDX) ? '0 : r_prev_idx + 1'b1;
    assign w_adv       = w_legal && r_prev_valid && (w_idx == w_next_idx);
    assign w_hold      = w_legal && r_prev_valid && (w_idx == r_prev_idx);
    assign w_bad       = !w_legal || (r_prev_valid && !w_adv && !w_hold);
    assign w_rot       = w_adv && (r_state == LOCKED)
                       && (r_prev_idx == LAST_IDX);
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_cyc_inc   = cycle_cnt + 1'b1;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= UNLOCKED;
            r_q          <= '0;
            r_q_valid    <= 1'b0;
            r_prev_idx   <= '0;
            r_prev_valid <= 1'b0;
            r_match_cnt  <= '0;
            phase        <= '0;
            phase_idx    <= '0;
            locked       <= 1'b0;
            err          <= 1'b0;
            err_sticky   <= 1'b0;
            cycle_cnt    <= '0;
            wrap         <= 1'b0;
        end else begin
            err  <= 1'b0;
            wrap <= 1'b0;
            if (en) begin
                r_q       <= q_in;
                r_q_valid <= 1'b1;
                if (r_q_valid) begin
                    if (w_legal) begin
                        phase        <= P'(1) << w_idx;
                        phase_idx    <= w_idx;
                        r_prev_idx   <= w_idx;
                        r_prev_valid <= 1'b1;
                    end else begin
                        phase        <= '0;
                        r_prev_valid <= 1'b0;
                    end
                    unique case (r_state)
                        UNLOCKED: begin
                            if (w_adv) begin
                                if (w_match_inc == LOCK_V) begin
                                    r_state     <= LOCKED;
                                    locked      <= 1'b1;
                                    r_match_cnt <= '0;
                                end else begin
                                    r_match_cnt <= w_match_inc;
                                end
                            end else if (w_bad) begin
                                r_match_cnt <= '0;
                            end
                        end
                        LOCKED: begin
                            if (w_bad) begin
                                err         <= 1'b1;
                                err_sticky  <= 1'b1;
                                locked      <= 1'b0;
                                r_state     <= UNLOCKED;
                                r_match_cnt <= '0;
                            end else if (w_rot) begin
                                cycle_cnt <= w_cyc_inc;
                                wrap      <= (w_cyc_inc == '0);
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor with a 2-bit rotation counter.
module tb_johnson_phase_monitor;

    logic       clk;
    logic       clr;
    logic       en;
    logic [3:0] q_in;
    logic [7:0] phase;
    logic [2:0] phase_idx;
    logic       locked;
    logic       err;
    logic       err_sticky;
    logic [1:0] cycle_cnt;
    logic       wrap;

    int n_checks = 0;
    int n_err    = 0;
    int n_wrap   = 0;

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};

    johnson_phase_monitor #(.N(4), .LOCK_CNT(2), .CYC_W(2)) dut (
        .clk        (clk),
        .clr        (clr),
        .en         (en),
        .q_in       (q_in),
        .phase      (phase),
        .phase_idx  (phase_idx),
        .locked     (locked),
        .err        (err),
        .err_sticky (err_sticky),
        .cycle_cnt  (cycle_cnt),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] q);
        q_in = q;
        en   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] q);
        q_in = q;
        en   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".phase"}, 32'(phase), 0);
        chk({tag, ".idx"}, 32'(phase_idx), 0);
        chk({tag, ".locked"}, 32'(locked), 0);
        chk({tag, ".err"}, 32'(err), 0);
        chk({tag, ".sticky"}, 32'(err_sticky), 0);
        chk({tag, ".cyc"}, 32'(cycle_cnt), 0);
        chk({tag, ".wrap"}, 32'(wrap), 0);
    endtask

    initial begin
        clr  = 1'b1;
        en   = 1'b0;
        q_in = 4'b0000;
        #12;
        chk_zero("rst");
        clr = 1'b0;

        // acquire lock: REF then two advances
        drive(4'b0000);
        drive(4'b0001);
        chk("ref.phase", 32'(phase), 32'h01);
        chk("ref.locked", 32'(locked), 0);
        drive(4'b0011);
        chk("adv1.locked", 32'(locked), 0);
        drive(4'b0111);
        chk("lock.locked", 32'(locked), 1);
        chk("lock.phase", 32'(phase), 32'h04);
        chk("lock.idx", 32'(phase_idx), 2);
        chk("lock.err", 32'(err), 0);
        chk("lock.sticky", 32'(err_sticky), 0);

        drive(4'b1111);
        drive(4'b1110);
        drive(4'b1100);
        drive(4'b1000);
        chk("pre_rot.cyc", 32'(cycle_cnt), 0);

        // 32 clean steps; rotations land on i = 1, 9, 17, 25
        for (int i = 0; i < 32; i++) begin
            drive(codes[i % 8]);
            chk("rot.wrap", 32'(wrap), 32'(i == 25));
            chk("rot.err", 32'(err), 0);
            if (wrap) n_wrap++;
            if (i == 15) chk("rot16.cyc", 32'(cycle_cnt), 2);
        end
        chk("rot32.cyc", 32'(cycle_cnt), 0);
        chk("rot32.nwrap", 32'(n_wrap), 1);
        chk("rot32.locked", 32'(locked), 1);

        // illegal code while locked
        drive(4'b0000);
        drive(4'b0001);
        drive(4'b0011);
        drive(4'b0101);
        chk("ill.pre_phase", 32'(phase), 32'h04);
        drive(4'b0000);
        chk("ill.phase", 32'(phase), 0);
        chk("ill.idx", 32'(phase_idx), 2);
        chk("ill.err", 32'(err), 1);
        chk("ill.locked", 32'(locked), 0);
        chk("ill.sticky", 32'(err_sticky), 1);
        chk("ill.cyc", 32'(cycle_cnt), 1);
        drive(4'b0001);
        chk("ill.err_pulse", 32'(err), 0);
        chk("ill.ref_phase", 32'(phase), 32'h01);
        chk("ill.ref_locked", 32'(locked), 0);
        drive(4'b0011);
        chk("ill.adv1_locked", 32'(locked), 0);
        drive(4'b1111);
        chk("relock.locked", 32'(locked), 1);
        chk("relock.phase", 32'(phase), 32'h04);
        chk("relock.sticky", 32'(err_sticky), 1);

        // skipped step 0011 -> 1111
        drive(4'b1111);
        chk("skip.err", 32'(err), 1);
        chk("skip.locked", 32'(locked), 0);
        chk("skip.phase", 32'(phase), 32'h10);
        chk("skip.idx", 32'(phase_idx), 4);
        drive(4'b1110);
        chk("skip.err_pulse", 32'(err), 0);

        // relock, then backward step 0111 -> 0011
        drive(4'b1100);
        drive(4'b1000);
        chk("bk.locked", 32'(locked), 1);
        drive(4'b0000);
        drive(4'b0001);
        chk("bk.cyc", 32'(cycle_cnt), 2);
        drive(4'b0011);
        drive(4'b0111);
        drive(4'b0011);
        chk("bk.pre_err", 32'(err), 0);
        drive(4'b0011);
        chk("bk.err", 32'(err), 1);
        chk("bk.locked", 32'(locked), 0);
        chk("bk.phase", 32'(phase), 32'h04);

        // backward legal step while unlocked gives no err
        drive(4'b0000);
        drive(4'b0001);
        chk("ubad.err", 32'(err), 0);
        chk("ubad.phase", 32'(phase), 32'h01);
        drive(4'b0011);
        chk("ubad.locked", 32'(locked), 0);
        drive(4'b0111);
        chk("ubad.relock", 32'(locked), 1);

        // hold 0111 for three edges
        drive(4'b0111);
        drive(4'b0111);
        chk("hold.err1", 32'(err), 0);
        drive(4'b0111);
        chk("hold.err", 32'(err), 0);
        chk("hold.locked", 32'(locked), 1);
        chk("hold.phase", 32'(phase), 32'h08);
        chk("hold.idx", 32'(phase_idx), 3);

        // enable gap with changing input
        idle(4'b0101);
        idle(4'b1010);
        idle(4'b0001);
        idle(4'b1100);
        idle(4'b0110);
        chk("gap.phase", 32'(phase), 32'h08);
        chk("gap.idx", 32'(phase_idx), 3);
        chk("gap.locked", 32'(locked), 1);
        chk("gap.err", 32'(err), 0);
        chk("gap.cyc", 32'(cycle_cnt), 2);
        drive(4'b1111);
        chk("resume.err0", 32'(err), 0);
        drive(4'b1110);
        chk("resume.err", 32'(err), 0);
        chk("resume.phase", 32'(phase), 32'h10);
        chk("resume.locked", 32'(locked), 1);

        // reach cycle_cnt=3 then reset between edges
        drive(4'b1100);
        drive(4'b1000);
        drive(4'b0000);
        drive(4'b0001);
        chk("pre_clr.cyc", 32'(cycle_cnt), 3);
        chk("pre_clr.locked", 32'(locked), 1);
        #2;
        clr = 1'b1;
        #1;
        chk_zero("aclr");
        @(posedge clk);
        #1;
        clr = 1'b0;
        drive(4'b0000);
        drive(4'b0001);
        chk("post.ref_locked", 32'(locked), 0);
        drive(4'b0011);
        chk("post.adv1_locked", 32'(locked), 0);
        drive(4'b0111);
        chk("post.locked", 32'(locked), 1);
        chk("post.sticky", 32'(err_sticky), 0);
        chk("post.cyc", 32'(cycle_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
